alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide parameter: PRIO_FIXED, 0, 0 = round-robin between requesters, 1 = requester 0 always wins ties.
REQ-002 SHALL provide ports (name  direction  width  meaning):
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req0_valid / req1_valid  input  1  request pending
- req0_ready / req1_ready  output  1  request accepted this cycle when valid&ready
- req0_op / req1_op  input  2  00 pass a, 01 a+b, 10 a-b, 11 pass b
- req0_a, req0_b / req1_a, req1_b  input  8  operands
- rsp0_valid / rsp1_valid  output  1  result available
- rsp0_ready / rsp1_ready  input  1  requester takes result
- rsp0_data / rsp1_data  output  8  result
- alu_operand1, alu_operand2  output  8  drive shared ALU operands
- alu_op  output  2  drive shared ALU select, same encoding as reqN_op
- alu_result  input  8  combinational ALU result
- busy  output  1  high in any state other than IDLE
REQ-003 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-004 SHALL implement FSM with states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-005 IDLE: grant computed combinationally from valids; reqN_ready = (IDLE && grant==N); at most one ready high per cycle.
REQ-006 On acceptance (valid&ready), capture op, a, b and requester index; next state EXEC.
REQ-007 EXEC (exactly one cycle): alu_op = captured op, operands = captured a/b; register alu_result at cycle end; next state RESP.
REQ-008 Outside EXEC: alu_op = 00; alu_operand1/2 hold last captured values.
REQ-009 RESP: rspN_valid high only for captured requester, rspN_data = registered result, both stable until rspN_ready; on rspN_valid&rspN_ready go IDLE.
REQ-010 Latency: accept in cycle T -> rsp valid from T+2; next acceptance no earlier than the cycle after the response handshake.
REQ-011 Round-robin (PRIO_FIXED=0): when both valid, grant the requester not last accepted; last-accepted pointer updates only on acceptance.
REQ-012 PRIO_FIXED=1: requester 0 wins whenever req0_valid; requester 1 granted only when req0_valid low.
REQ-013 Single valid requester SHALL be granted regardless of pointer.
REQ-014 Arithmetic is modulo 256 (provided by ALU); block SHALL pass alu_result unmodified (0xFF+0x01 -> 0x00, 0x00-0x01 -> 0xFF).
REQ-015 Requests arriving while busy SHALL see ready low and are not dropped while valid stays high.
REQ-016 rspN_ready asserted while rspN_valid low SHALL have no effect.

Reset
REQ-017 rst_n low SHALL immediately force: state IDLE, reqN_ready per IDLE grant rule, rspN_valid 0, rspN_data 0x00, alu_operand1/2 0x00, alu_op 00, busy 0, last-accepted pointer = requester 1 (so requester 0 wins first tie).
REQ-018 Reset during EXEC or RESP SHALL abandon the transaction; no response is produced after release.

Configuration
REQ-019 Macro ALU_ARB_FLAGS_EN defined: add outputs rsp_zero (1, result==0x00) and rsp_neg (1, result bit7), registered with the result, valid with rspN_valid, reset to 0.
REQ-020 Macro ALU_ARB_FLAGS_EN undefined: rsp_zero and rsp_neg ports absent; all other behaviour identical.

Verification
REQ-021 Reset release, req0 op=01 a=0x12 b=0x34 -> req0_ready at T, alu_op=01 at T+1, rsp0_valid with 0x46 at T+2.
REQ-022 Both valid every cycle, PRIO_FIXED=0, rsp_ready held 1 -> grants alternate 0,1,0,1; PRIO_FIXED=1 -> only req0 served.
REQ-023 req1 op=10 a=0x00 b=0x01, rsp1_ready low 5 cycles -> rsp1_valid held, data 0xFF stable; ALU_ARB_FLAGS_EN: rsp_neg=1, rsp_zero=0.
REQ-024 req0 op=01 a=0xFF b=0x01 -> data 0x00 (rsp_zero=1 if flags on); op=11 a=0xAA b=0x55 -> 0x55; op=00 -> 0xAA.
REQ-025 rst_n pulsed low during RESP -> rsp valid drops immediately, outputs at reset values, no response after release, next tie granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : two-requester front end sharing one combinational ALU
//   (IDLE/EXEC/RESP). Optional macro ALU_ARB_FLAGS_EN adds rsp_zero/rsp_neg.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic [7:0] rsp0_data,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp1_data,
  output logic [7:0] alu_operand1,
  output logic [7:0] alu_operand2,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       busy
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic       rsp_zero,
  output logic       rsp_neg
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       idx_q, idx_d;
  logic       last_q, last_d;
  logic [1:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q, result_d;
`ifdef ALU_ARB_FLAGS_EN
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;
`endif

  logic gnt_valid;
  logic gnt_idx;
  logic rsp_hs;

  // Tie-break: fixed priority to 0, or the requester not accepted last.
  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    gnt_idx   = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_idx = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
    end else if (req1_valid) begin
      gnt_idx = 1'b1;
    end
  end

  assign req0_ready = (state_q == IDLE) && gnt_valid && !gnt_idx;
  assign req1_ready = (state_q == IDLE) && gnt_valid &&  gnt_idx;
  assign rsp_hs     = (state_q == RESP) && (idx_q ? rsp1_ready : rsp0_ready);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef ALU_ARB_FLAGS_EN
    zero_d   = zero_q;
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          idx_d   = gnt_idx;
          last_d  = gnt_idx;
          op_d    = gnt_idx ? req1_op : req0_op;
          a_d     = gnt_idx ? req1_a  : req0_a;
          b_d     = gnt_idx ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
`ifdef ALU_ARB_FLAGS_EN
        zero_d   = (alu_result == 8'h00);
        neg_d    = alu_result[7];
`endif
        state_d  = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointer resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 1'b0;
      last_q   <= 1'b1;
      op_q     <= 2'b00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
`ifdef ALU_ARB_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef ALU_ARB_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`endif
    end
  end

  assign alu_op       = (state_q == EXEC) ? op_q : 2'b00;
  assign alu_operand1 = a_q;
  assign alu_operand2 = b_q;
  assign rsp0_valid   = (state_q == RESP) && !idx_q;
  assign rsp1_valid   = (state_q == RESP) &&  idx_q;
  assign rsp0_data    = result_q;
  assign rsp1_data    = result_q;
  assign busy         = (state_q != IDLE);
`ifdef ALU_ARB_FLAGS_EN
  assign rsp_zero     = zero_q;
  assign rsp_neg      = neg_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed bench for alu_arbiter (round-robin and fixed
//   priority instances, each driven by a behavioural ALU). Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [7:0] rsp0_data, rsp1_data, opnd1, opnd2, alu_result;
  logic [1:0] alu_op;
  logic       busy;

  logic       f_v0, f_v1, f_rdy0, f_rdy1, f_rv0, f_rv1, f_rr0, f_rr1;
  logic [1:0] f_op0, f_op1, f_alu_op;
  logic [7:0] f_a0, f_b0, f_a1, f_b1, f_d0, f_d1, f_opnd1, f_opnd2, f_alu_result;
  logic       f_busy;
`ifdef ALU_ARB_FLAGS_EN
  logic       rsp_zero, rsp_neg, f_zero, f_neg;
`endif

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'b00:   return a;
      2'b01:   return a + b;
      2'b10:   return a - b;
      default: return b;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_op, opnd1, opnd2);
  assign f_alu_result = alu_f(f_alu_op, f_opnd1, f_opnd2);

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_operand1(opnd1), .alu_operand2(opnd2), .alu_op(alu_op), .alu_result(alu_result),
    .busy(busy)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_neg(rsp_neg)
`endif
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_v0), .req0_ready(f_rdy0), .req0_op(f_op0), .req0_a(f_a0), .req0_b(f_b0),
    .req1_valid(f_v1), .req1_ready(f_rdy1), .req1_op(f_op1), .req1_a(f_a1), .req1_b(f_b1),
    .rsp0_valid(f_rv0), .rsp0_ready(f_rr0), .rsp0_data(f_d0),
    .rsp1_valid(f_rv1), .rsp1_ready(f_rr1), .rsp1_data(f_d1),
    .alu_operand1(f_opnd1), .alu_operand2(f_opnd2), .alu_op(f_alu_op), .alu_result(f_alu_result),
    .busy(f_busy)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_zero(f_zero), .rsp_neg(f_neg)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One complete transaction from an idle arbiter; response held 'hold' extra cycles.
  task automatic txn(input logic idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] exp, input int hold);
    if (!idx) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    chk1("acc_ready", idx ? req1_ready : req0_ready, 1'b1);
    chk1("acc_other_ready", idx ? req0_ready : req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk8("exec_op", {6'd0, alu_op}, {6'd0, op});
    chk8("exec_opnd1", opnd1, a);
    chk8("exec_opnd2", opnd2, b);
    chk1("exec_busy", busy, 1'b1);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      #1;
      chk1("rsp_valid", idx ? rsp1_valid : rsp0_valid, 1'b1);
      chk1("rsp_other_valid", idx ? rsp0_valid : rsp1_valid, 1'b0);
      chk8("rsp_data", idx ? rsp1_data : rsp0_data, exp);
      chk8("rsp_alu_op_idle", {6'd0, alu_op}, 8'h00);
`ifdef ALU_ARB_FLAGS_EN
      chk1("rsp_zero", rsp_zero, exp == 8'h00);
      chk1("rsp_neg", rsp_neg, exp[7]);
`endif
    end
    if (idx) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    chk1("done_busy", busy, 1'b0);
    chk1("done_rsp_valid", idx ? rsp1_valid : rsp0_valid, 1'b0);
  endtask

  initial begin
    int cnt0;
    int cnt_rv0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_op = 2'b00; req1_op = 2'b00; req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    f_v0 = 1'b0; f_v1 = 1'b0; f_rr0 = 1'b0; f_rr1 = 1'b0;
    f_op0 = 2'b00; f_a0 = 8'h10; f_b0 = 8'h00; f_op1 = 2'b00; f_a1 = 8'h20; f_b1 = 8'h00;

    // Reset state, including the IDLE grant seen while held in reset.
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk8("rst_alu_op", {6'd0, alu_op}, 8'h00);
    chk8("rst_opnd1", opnd1, 8'h00);
    chk8("rst_opnd2", opnd2, 8'h00);
    chk8("rst_rsp0_data", rsp0_data, 8'h00);
    chk1("rst_req0_ready", req0_ready, 1'b1);
    chk1("rst_req1_ready", req1_ready, 1'b0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with latency T -> T+1 exec -> T+2 response.
    txn(1'b0, 2'b01, 8'h12, 8'h34, 8'h46, 0);

    // Subtract underflow, response back-pressured for 5 cycles while req0 waits.
    req1_valid = 1'b1; req1_op = 2'b10; req1_a = 8'h00; req1_b = 8'h01;
    #1;
    chk1("sub_req1_ready", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b11; req0_a = 8'h00; req0_b = 8'h77; rsp0_ready = 1'b1;
    #1;
    chk1("busy_req0_ready_exec", req0_ready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk1("hold_rsp1_valid", rsp1_valid, 1'b1);
      chk8("hold_rsp1_data", rsp1_data, 8'hFF);
      chk1("hold_rsp0_valid", rsp0_valid, 1'b0);
      chk1("hold_req0_ready", req0_ready, 1'b0);
`ifdef ALU_ARB_FLAGS_EN
      chk1("hold_neg", rsp_neg, 1'b1);
      chk1("hold_zero", rsp_zero, 1'b0);
`endif
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    chk1("after_hs_rsp1_valid", rsp1_valid, 1'b0);
    chk1("waiting_req0_ready", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk8("waiting_exec_op", {6'd0, alu_op}, 8'h03);
    @(negedge clk);
    #1;
    chk1("waiting_rsp0_valid", rsp0_valid, 1'b1);
    chk8("waiting_rsp0_data", rsp0_data, 8'h77);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    chk1("waiting_done_busy", busy, 1'b0);

    // Wrap-around add, pass b, pass a.
    txn(1'b0, 2'b01, 8'hFF, 8'h01, 8'h00, 0);
    txn(1'b0, 2'b11, 8'hAA, 8'h55, 8'h55, 0);
    txn(1'b0, 2'b00, 8'hAA, 8'h55, 8'hAA, 1);

    // Reset pulse during RESP abandons the transaction.
    req0_valid = 1'b1; req0_op = 2'b01; req0_a = 8'h01; req0_b = 8'h02;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    chk1("pre_rst_rsp0_valid", rsp0_valid, 1'b1);
    chk8("pre_rst_rsp0_data", rsp0_data, 8'h03);
    rst_n = 1'b0;
    #1;
    chk1("midrst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk8("midrst_data", rsp0_data, 8'h00);
    chk8("midrst_opnd1", opnd1, 8'h00);
    chk8("midrst_opnd2", opnd2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1; rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk1("postrst_rsp0_valid", rsp0_valid, 1'b0);
      chk1("postrst_busy", busy, 1'b0);
    end

    // Round-robin with both requesters always valid: 0,1,0,1.
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 8'h10; req0_b = 8'h00;
    req1_valid = 1'b1; req1_op = 2'b00; req1_a = 8'h20; req1_b = 8'h00;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic e1;
      e1 = (k % 2) == 1;
      #1;
      chk1("rr_req0_ready", req0_ready, !e1);
      chk1("rr_req1_ready", req1_ready, e1);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk1("rr_rsp0_valid", rsp0_valid, !e1);
      chk1("rr_rsp1_valid", rsp1_valid, e1);
      chk8("rr_data", e1 ? rsp1_data : rsp0_data, e1 ? 8'h20 : 8'h10);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Fixed priority: only requester 0 is ever served.
    f_v0 = 1'b1; f_v1 = 1'b1; f_rr0 = 1'b1; f_rr1 = 1'b1;
    cnt0 = 0; cnt_rv0 = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk1("fx_req1_ready", f_rdy1, 1'b0);
      chk1("fx_rsp1_valid", f_rv1, 1'b0);
      if (f_rdy0) cnt0++;
      if (f_rv0) begin
        cnt_rv0++;
        chk8("fx_rsp0_data", f_d0, 8'h10);
      end
      @(negedge clk);
    end
    chk8("fx_grant_count", 8'(cnt0), 8'd4);
    chk8("fx_rsp_count", 8'(cnt_rv0), 8'd4);
    f_v0 = 1'b0; f_v1 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
